// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot datapath: fixed-point format,
// iteration-count width and the dispatcher state encoding.
package mandel_pkg;
    localparam int FIXED_W  = 27;
    localparam int FRAC_W   = 23;
    localparam int ITER_MAX = 255;
    localparam int ITER_W   = $clog2(ITER_MAX) + 1;

    typedef logic [FIXED_W-1:0] fixed_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } disp_state_e;

    function automatic fixed_t fixed_from_int(input int v);
        return fixed_t'(v) << FRAC_W;
    endfunction
endpackage

// File: rtl/iter_dispatcher_if.sv
// Handshake bundle between the dispatcher, the escape-time iterator and the
// pixel sink. The dispatcher drives the master side.
interface iter_dispatcher_if
    import mandel_pkg::*;
#(
    parameter int ITER_W = mandel_pkg::ITER_W,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
);
    logic              it_in_val;
    logic              it_in_rdy;
    fixed_t            it_c_r;
    fixed_t            it_c_i;
    logic              it_out_val;
    logic [ITER_W-1:0] it_iter_count;
    logic              it_out_rdy;
    logic              pix_val;
    logic              pix_rdy;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;
    logic [ITER_W-1:0] pix_iter;

    modport master (
        output it_in_val, it_c_r, it_c_i, it_out_rdy,
        output pix_val, pix_x, pix_y, pix_iter,
        input  it_in_rdy, it_out_val, it_iter_count, pix_rdy
    );

    modport slave (
        input  it_in_val, it_c_r, it_c_i, it_out_rdy,
        input  pix_val, pix_x, pix_y, pix_iter,
        output it_in_rdy, it_out_val, it_iter_count, pix_rdy
    );
endinterface

// File: rtl/coord_stepper.sv
// Raster position and complex-plane coordinate tracker for one frame.
// Real axis grows left to right, imaginary axis shrinks top to bottom.
module coord_stepper
    import mandel_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int X_W      = $clog2(SCREEN_W),
    parameter int Y_W      = $clog2(SCREEN_H)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           advance_i,
    input  fixed_t         c_r_start_i,
    input  fixed_t         c_i_start_i,
    input  fixed_t         step_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output fixed_t         cur_r_o,
    output fixed_t         cur_i_o,
    output logic           last_col_o,
    output logic           last_row_o
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    fixed_t         cur_r_q, cur_r_d;
    fixed_t         cur_i_q, cur_i_d;
    fixed_t         r_base_q, r_base_d;
    fixed_t         step_q, step_d;

    assign last_col_o = (x_q == X_W'(SCREEN_W - 1));
    assign last_row_o = (y_q == Y_W'(SCREEN_H - 1));

    // Plain modulo-2^27 arithmetic: wrap-around is intended, no saturation.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        cur_r_d  = cur_r_q;
        cur_i_d  = cur_i_q;
        r_base_d = r_base_q;
        step_d   = step_q;
        if (load_i) begin
            x_d      = '0;
            y_d      = '0;
            cur_r_d  = c_r_start_i;
            cur_i_d  = c_i_start_i;
            r_base_d = c_r_start_i;
            step_d   = step_i;
        end else if (advance_i) begin
            if (last_col_o) begin
                x_d     = '0;
                y_d     = y_q + 1'b1;
                cur_r_d = r_base_q;
                cur_i_d = cur_i_q - step_q;
            end else begin
                x_d     = x_q + 1'b1;
                cur_r_d = cur_r_q + step_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            cur_r_q  <= '0;
            cur_i_q  <= '0;
            r_base_q <= '0;
            step_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            cur_r_q  <= cur_r_d;
            cur_i_q  <= cur_i_d;
            r_base_q <= r_base_d;
            step_q   <= step_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign cur_r_o = cur_r_q;
    assign cur_i_o = cur_i_q;
endmodule

// File: rtl/iter_dispatcher.sv
// Walks a frame in raster order, hands one coordinate at a time to the
// iterator and forwards each result to the pixel sink.
//   state | meaning
//   IDLE  | waiting for start, parameters latched on start
//   ISSUE | offering current coordinate to the iterator
//   WAIT  | coordinate accepted, waiting for iteration count
//   WRITE | offering pixel to the sink
//   FIN   | one-cycle frame_done pulse
module iter_dispatcher
    import mandel_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ITER_W   = mandel_pkg::ITER_W
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  fixed_t c_r_start,
    input  fixed_t c_i_start,
    input  fixed_t step,
    output logic   busy,
    output logic   frame_done,
    iter_dispatcher_if.master bus
);
    localparam int X_W = $clog2(SCREEN_W);
    localparam int Y_W = $clog2(SCREEN_H);

    disp_state_e       state_q;
    logic              it_in_val_q;
    logic              it_out_rdy_q;
    logic              pix_val_q;
    logic              busy_q;
    logic              frame_done_q;
    logic [X_W-1:0]    pix_x_q;
    logic [Y_W-1:0]    pix_y_q;
    logic [ITER_W-1:0] pix_iter_q;

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    fixed_t         cur_r;
    fixed_t         cur_i;
    logic           last_col;
    logic           last_row;
    logic           load;
    logic           advance;

    assign load    = (state_q == ST_IDLE) && start;
    assign advance = (state_q == ST_WRITE) && bus.pix_rdy && !(last_col && last_row);

    coord_stepper #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_stepper (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .advance_i   (advance),
        .c_r_start_i (c_r_start),
        .c_i_start_i (c_i_start),
        .step_i      (step),
        .x_o         (x),
        .y_o         (y),
        .cur_r_o     (cur_r),
        .cur_i_o     (cur_i),
        .last_col_o  (last_col),
        .last_row_o  (last_row)
    );

    // Handshake outputs are registered alongside the state so that no input
    // reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            it_in_val_q  <= 1'b0;
            it_out_rdy_q <= 1'b0;
            pix_val_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_iter_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_ISSUE;
                        it_in_val_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.it_in_rdy) begin
                        state_q      <= ST_WAIT;
                        it_in_val_q  <= 1'b0;
                        it_out_rdy_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.it_out_val) begin
                        state_q      <= ST_WRITE;
                        it_out_rdy_q <= 1'b0;
                        pix_val_q    <= 1'b1;
                        pix_x_q      <= x;
                        pix_y_q      <= y;
                        pix_iter_q   <= bus.it_iter_count;
                    end
                end
                ST_WRITE: begin
                    if (bus.pix_rdy) begin
                        pix_val_q <= 1'b0;
                        if (last_col && last_row) begin
                            state_q      <= ST_FIN;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            it_in_val_q <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_q      <= ST_IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    it_in_val_q  <= 1'b0;
                    it_out_rdy_q <= 1'b0;
                    pix_val_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.it_in_val  = it_in_val_q;
    assign bus.it_c_r     = cur_r;
    assign bus.it_c_i     = cur_i;
    assign bus.it_out_rdy = it_out_rdy_q;
    assign bus.pix_val    = pix_val_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_iter   = pix_iter_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_iter_dispatcher.sv
// Scoreboard bench for iter_dispatcher on a 4x2 frame, with a behavioural
// iterator and pixel sink driving randomized handshakes.
module tb_iter_dispatcher;
    import mandel_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int IW = mandel_pkg::ITER_W;

    logic   clk = 1'b0;
    logic   reset;
    logic   start;
    fixed_t c_r_start, c_i_start, step;
    logic   busy, frame_done;

    iter_dispatcher_if #(.ITER_W(IW), .X_W(XW), .Y_W(YW)) bus ();

    iter_dispatcher #(.SCREEN_W(W), .SCREEN_H(H), .ITER_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .c_r_start  (c_r_start),
        .c_i_start  (c_i_start),
        .step       (step),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed { fixed_t r; fixed_t i; } coord_t;
    typedef struct packed { logic [XW-1:0] x; logic [YW-1:0] y; logic [IW-1:0] it; } pix_t;

    coord_t exp_coord_q[$];
    pix_t   exp_pix_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_frames = 0;
    int     frames_seen = 0;

    int it_lat = 0;
    int in_stall = 0;
    int pix_stall = 0;
    bit in_rand = 1'b0;
    bit it_flush = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %s (t=%0t)", name, what, $time);
    endtask

    // Ideal iterator: any fixed function of the coordinate that spreads values.
    function automatic logic [IW-1:0] iter_of(input fixed_t r, input fixed_t i);
        fixed_t t;
        t = r * fixed_t'(27'd2654435) + i * fixed_t'(27'd40503) + (r >> 9);
        return IW'(t >> (FIXED_W - IW));
    endfunction

    // Reference: pixel (x,y) sits at (cr + x*step, ci - y*step) modulo 2^27.
    task automatic push_frame(input fixed_t cr, input fixed_t ci, input fixed_t st);
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                coord_t c;
                pix_t   p;
                c.r  = cr + fixed_t'(xx) * st;
                c.i  = ci - fixed_t'(yy) * st;
                p.x  = XW'(xx);
                p.y  = YW'(yy);
                p.it = iter_of(c.r, c.i);
                exp_coord_q.push_back(c);
                exp_pix_q.push_back(p);
            end
        end
    endtask

    initial begin : iterator_model
        logic        iv, ihs, ohs, pending;
        fixed_t      scr, sci;
        int          cnt;
        logic [IW-1:0] res;
        pending = 1'b0;
        cnt = 0;
        res = '0;
        bus.it_in_rdy = 1'b0;
        bus.it_out_val = 1'b0;
        bus.it_iter_count = '0;
        forever begin
            @(negedge clk);
            iv  = bus.it_in_val && !reset;
            ihs = iv && bus.it_in_rdy;
            ohs = bus.it_out_val && bus.it_out_rdy && !reset;
            scr = bus.it_c_r;
            sci = bus.it_c_i;
            @(posedge clk);
            #1;
            if (it_flush) begin
                pending = 1'b0;
                bus.it_out_val = 1'b0;
                it_flush = 1'b0;
            end else begin
                if (ohs) begin
                    bus.it_out_val = 1'b0;
                    pending = 1'b0;
                end
                if (ihs) begin
                    pending = 1'b1;
                    cnt = (it_lat < 0) ? int'($urandom_range(0, 6)) : it_lat;
                    res = iter_of(scr, sci);
                end else if (pending && !bus.it_out_val) begin
                    if (cnt == 0) begin
                        bus.it_out_val = 1'b1;
                        bus.it_iter_count = res;
                    end else begin
                        cnt--;
                    end
                end
            end
            if (in_stall > 0) begin
                bus.it_in_rdy = 1'b0;
                if (iv) in_stall--;
            end else begin
                bus.it_in_rdy = in_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin : pixel_sink
        logic v, hs;
        int   pw;
        pw = 0;
        bus.pix_rdy = 1'b0;
        forever begin
            @(negedge clk);
            v  = bus.pix_val && !reset;
            hs = v && bus.pix_rdy;
            @(posedge clk);
            #1;
            if (hs || !v) pw = 0;
            else pw++;
            if (pix_stall < 0) bus.pix_rdy = 1'($urandom_range(0, 1));
            else bus.pix_rdy = (pw >= pix_stall);
        end
    end

    initial begin : coord_monitor
        coord_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.it_in_val && bus.it_in_rdy) begin
                if (exp_coord_q.size() == 0) begin
                    fail_event("coord_extra", $sformatf("r=0x%0h i=0x%0h, required no transfer", bus.it_c_r, bus.it_c_i));
                end else begin
                    e = exp_coord_q.pop_front();
                    check("it_c_r", 64'(bus.it_c_r), 64'(e.r));
                    check("it_c_i", 64'(bus.it_c_i), 64'(e.i));
                end
            end
        end
    end

    initial begin : pixel_monitor
        pix_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.pix_val && bus.pix_rdy) begin
                if (exp_pix_q.size() == 0) begin
                    fail_event("pix_extra", $sformatf("x=%0d y=%0d, required no pixel", bus.pix_x, bus.pix_y));
                end else begin
                    e = exp_pix_q.pop_front();
                    check("pix_x", 64'(bus.pix_x), 64'(e.x));
                    check("pix_y", 64'(bus.pix_y), 64'(e.y));
                    check("pix_iter", 64'(bus.pix_iter), 64'(e.it));
                end
            end
        end
    end

    initial begin : stability_monitor
        logic          p_iv, p_pv;
        fixed_t        p_r, p_i;
        logic [XW-1:0] p_x;
        logic [YW-1:0] p_y;
        logic [IW-1:0] p_it;
        p_iv = 1'b0;
        p_pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && p_iv) begin
                check("it_in_val_held", 64'(bus.it_in_val), 64'd1);
                check("it_c_r_stable", 64'(bus.it_c_r), 64'(p_r));
                check("it_c_i_stable", 64'(bus.it_c_i), 64'(p_i));
            end
            if (!reset && p_pv) begin
                check("pix_val_held", 64'(bus.pix_val), 64'd1);
                check("pix_x_stable", 64'(bus.pix_x), 64'(p_x));
                check("pix_y_stable", 64'(bus.pix_y), 64'(p_y));
                check("pix_iter_stable", 64'(bus.pix_iter), 64'(p_it));
            end
            p_iv = !reset && bus.it_in_val && !bus.it_in_rdy;
            p_pv = !reset && bus.pix_val && !bus.pix_rdy;
            p_r  = bus.it_c_r;
            p_i  = bus.it_c_i;
            p_x  = bus.pix_x;
            p_y  = bus.pix_y;
            p_it = bus.pix_iter;
        end
    end

    initial begin : done_monitor
        logic p_fd;
        p_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && p_fd) check("frame_done_one_cycle", 64'(frame_done), 64'd0);
            if (!reset && frame_done) begin
                frames_seen++;
                check("pixels_left_at_done", 64'(exp_pix_q.size()), 64'd0);
                check("busy_in_fin", 64'(busy), 64'd1);
            end
            p_fd = !reset && frame_done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_it_in_val"}, 64'(bus.it_in_val), 64'd0);
        check({tag, "_it_out_rdy"}, 64'(bus.it_out_rdy), 64'd0);
        check({tag, "_pix_val"}, 64'(bus.pix_val), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_pix_x"}, 64'(bus.pix_x), 64'd0);
        check({tag, "_pix_y"}, 64'(bus.pix_y), 64'd0);
        check({tag, "_pix_iter"}, 64'(bus.pix_iter), 64'd0);
        check({tag, "_it_c_r"}, 64'(bus.it_c_r), 64'd0);
        check({tag, "_it_c_i"}, 64'(bus.it_c_i), 64'd0);
    endtask

    task automatic reset_mid(input string tag, input bit flush);
        @(posedge clk);
        #1;
        reset = 1'b1;
        if (flush) it_flush = 1'b1;
        @(posedge clk);
        #1;
        exp_coord_q.delete();
        exp_pix_q.delete();
        exp_frames = frames_seen;
        check_reset_outputs(tag);
        reset = 1'b0;
    endtask

    task automatic start_frame(input fixed_t cr, input fixed_t ci, input fixed_t st);
        @(posedge clk);
        #1;
        c_r_start = cr;
        c_i_start = ci;
        step      = st;
        start     = 1'b1;
        push_frame(cr, ci, st);
        exp_frames++;
        @(posedge clk);
        #1;
        start     = 1'b0;
        c_r_start = fixed_t'($urandom);
        c_i_start = fixed_t'($urandom);
        step      = fixed_t'($urandom);
    endtask

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (frames_seen != exp_frames && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (frames_seen != exp_frames) begin
            fail_event(tag, $sformatf("%0d frame_done pulses after %0d cycles, required %0d", frames_seen, k, exp_frames));
            reset_mid({tag, "_recover"}, 1'b1);
        end else begin
            @(posedge clk);
            #1;
            check({tag, "_busy_after"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic wait_state(input string tag, input bit want_write);
        int k;
        k = 0;
        while (!(want_write ? bus.pix_val : bus.it_out_rdy) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!(want_write ? bus.pix_val : bus.it_out_rdy))
            fail_event(tag, $sformatf("state not reached in %0d cycles", k));
    endtask

    initial begin : watchdog
        #600000;
        n_errors++;
        $display("FAIL watchdog: simulation time exhausted, required self-termination");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1;
        start = 1'b0;
        c_r_start = '0;
        c_i_start = '0;
        step = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // -2.0 + 1.0i, step 0.5, ideal iterator
        run_basic: begin
            it_lat = 0; in_stall = 0; pix_stall = 0; in_rand = 1'b0;
            start_frame(27'h7000000, 27'h0800000, 27'h0400000);
            wait_frame("basic");
        end

        it_lat = 37; pix_stall = 5;
        start_frame(27'h7000000, 27'h0800000, 27'h0400000);
        wait_frame("slow");

        it_lat = -1; pix_stall = 0; in_stall = 10;
        start_frame(27'h7800000, 27'h0400000, 27'h0200000);
        wait_frame("in_stall");

        it_lat = -1; pix_stall = -1; in_rand = 1'b1;
        start_frame(27'h7000000, 27'h0800000, 27'h0400000);
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_midstart", 64'(busy), 64'd1);
        c_r_start = 27'h1234567;
        c_i_start = 27'h0765432;
        step = 27'h0011111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frame("midstart");

        it_lat = 37; pix_stall = 0; in_rand = 1'b0;
        start_frame(27'h7000000, 27'h0800000, 27'h0400000);
        wait_state("reach_wait", 1'b0);
        reset_mid("rst_wait", 1'b0);
        repeat (45) @(negedge clk);
        check("stale_result_ignored_rdy", 64'(bus.it_out_rdy), 64'd0);
        check("stale_result_no_pix", 64'(bus.pix_val), 64'd0);
        check("stale_result_idle", 64'(busy), 64'd0);
        it_flush = 1'b1;
        repeat (3) @(posedge clk);
        it_lat = 2;
        start_frame(27'h7000000, 27'h0800000, 27'h0400000);
        wait_frame("after_rst_wait");

        it_lat = 1; pix_stall = 30;
        start_frame(27'h7C00000, 27'h0000000, 27'h0100000);
        wait_state("reach_write", 1'b1);
        reset_mid("rst_write", 1'b1);
        pix_stall = 0;
        start_frame(27'h7000000, 27'h0800000, 27'h0400000);
        wait_frame("after_rst_write");

        // largest positive real plus one LSB wraps to the most negative value
        it_lat = 0; pix_stall = 0;
        start_frame(27'h3FFFFFF, fixed_t'($urandom), 27'h0000001);
        wait_frame("wrap");

        it_lat = -1; pix_stall = -1; in_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            start_frame(fixed_t'($urandom), fixed_t'($urandom), fixed_t'($urandom));
            wait_frame("random");
        end

        repeat (5) @(posedge clk);
        check("coord_queue_drained", 64'(exp_coord_q.size()), 64'd0);
        check("pixel_queue_drained", 64'(exp_pix_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
